// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: two read ports with hazard flags,
// one writeback port, one issue port and the pending-register count.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              hazard1;
  logic              hazard2;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data1, rd_data2, hazard1, hazard2, pend_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data1, rd_data2, hazard1, hazard2, pend_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// MIPS register file with per-register pending bits: two combinational read
// ports with optional writeback bypass, one write port, issue/writeback scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic                clk,
  input logic                rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_pending;
  logic [ADDR_W:0]              r_pend_cnt;

  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_iss_addr;
  logic              w_wr_en;
  logic              w_iss_en;
  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [DEPTH-1:0]  w_we;
  logic [DEPTH-1:0]  w_set;
  logic [DEPTH-1:0]  w_clr;
  logic [DEPTH-1:0]  w_pend_next;
  logic              w_inc;
  logic              w_dec;

  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_hazard  [2];

  assign w_wr_addr  = bus.wr_addr;
  assign w_wr_data  = bus.wr_data;
  assign w_iss_addr = bus.iss_addr;
  // Gating with rst_n keeps the bypass path quiet while reset is held.
  assign w_wr_en    = bus.wr_en & rst_n;
  assign w_iss_en   = bus.iss_en & rst_n;
  assign w_wr_ok    = w_wr_en  & ~((ZERO_REG != 0) && (w_wr_addr == '0));
  assign w_iss_ok   = w_iss_en & ~((ZERO_REG != 0) && (w_iss_addr == '0));

  assign w_rd_addr[0] = bus.rd_addr1;
  assign w_rd_addr[1] = bus.rd_addr2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign w_we[gi]  = w_wr_ok  && (w_wr_addr  == ADDR_W'(gi));
      assign w_set[gi] = w_iss_ok && (w_iss_addr == ADDR_W'(gi));
      assign w_clr[gi] = w_wr_en  && (w_wr_addr  == ADDR_W'(gi));
      // Issue beats writeback on the same register: the new producer owns it.
      assign w_pend_next[gi] = w_set[gi] | (r_pending[gi] & ~w_clr[gi]);
    end
  endgenerate

  // At most one bit rises (single issue) and one falls (single writeback).
  assign w_inc = |(w_pend_next & ~r_pending);
  assign w_dec = |(r_pending & ~w_pend_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem      <= '0;
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= w_wr_data;
        end
      end
      r_pending  <= w_pend_next;
      r_pend_cnt <= r_pend_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        w_rd_data[gi] = r_mem[w_rd_addr[gi]];
        w_hazard[gi]  = r_pending[w_rd_addr[gi]];
        if ((BYPASS != 0) && w_wr_ok && (w_wr_addr == w_rd_addr[gi])) begin
          w_rd_data[gi] = w_wr_data;
          w_hazard[gi]  = 1'b0;
        end
        if ((ZERO_REG != 0) && (w_rd_addr[gi] == '0)) begin
          w_rd_data[gi] = '0;
          w_hazard[gi]  = 1'b0;
        end
      end
    end
  endgenerate

  assign bus.rd_data1 = w_rd_data[0];
  assign bus.rd_data2 = w_rd_data[1];
  assign bus.hazard1  = w_hazard[0];
  assign bus.hazard2  = w_hazard[1];
  assign bus.pend_cnt = r_pend_cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_scoreboard;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_n)
  );

  assign bus_n.rd_addr1 = bus_b.rd_addr1;
  assign bus_n.rd_addr2 = bus_b.rd_addr2;
  assign bus_n.wr_en    = bus_b.wr_en;
  assign bus_n.wr_addr  = bus_b.wr_addr;
  assign bus_n.wr_data  = bus_b.wr_data;
  assign bus_n.iss_en   = bus_b.iss_en;
  assign bus_n.iss_addr = bus_b.iss_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle just after it so new inputs apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus_b.wr_en    = we;
    bus_b.wr_addr  = wa;
    bus_b.wr_data  = wd;
    bus_b.iss_en   = ie;
    bus_b.iss_addr = ia;
    bus_b.rd_addr1 = ra1;
    bus_b.rd_addr2 = ra2;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #10;
    chk("reset_pend_cnt", 64'(bus_b.pend_cnt), 64'd0);
    chk("reset_hazard1", 64'(bus_b.hazard1), 64'd0);
    rst_n = 1'b1;

    // Write r5 and issue r6, then pull reset between edges.
    step();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 5'd5, 5'd6);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    chk("r5_written", 64'(bus_b.rd_data1), 64'hDEADBEEF);
    chk("r6_pending_cnt", 64'(bus_b.pend_cnt), 64'd1);
    chk("r6_hazard2", 64'(bus_b.hazard2), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data1", 64'(bus_b.rd_data1), 64'd0);
    chk("async_rst_pend_cnt", 64'(bus_b.pend_cnt), 64'd0);
    chk("async_rst_hazard2", 64'(bus_b.hazard2), 64'd0);
    chk("async_rst_n_pend_cnt", 64'(bus_n.pend_cnt), 64'd0);
    #1;
    rst_n = 1'b1;

    // Write r7: bypass instance sees new data now, the other after the edge.
    step();
    drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("bypass_same_cycle", 64'(bus_b.rd_data1), 64'h12345678);
    chk("nobypass_old_value", 64'(bus_n.rd_data1), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("nobypass_after_edge", 64'(bus_n.rd_data1), 64'h12345678);

    // Register 0 ignores writes and issues.
    step();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("zero_rd_bypass", 64'(bus_b.rd_data1), 64'd0);
    chk("zero_hazard1", 64'(bus_b.hazard1), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("zero_rd_after", 64'(bus_n.rd_data2), 64'd0);
    chk("zero_hazard2", 64'(bus_n.hazard2), 64'd0);
    chk("zero_pend_cnt", 64'(bus_b.pend_cnt), 64'd0);

    // Issue r3, then writeback r3.
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    chk("r3_not_yet_pending", 64'(bus_b.hazard1), 64'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    chk("r3_hazard1", 64'(bus_b.hazard1), 64'd1);
    chk("r3_pend_cnt", 64'(bus_b.pend_cnt), 64'd1);
    step();
    drive(1'b1, 5'd3, 32'hAAAA5555, 1'b0, 5'd0, 5'd3, 5'd0);
    chk("r3_wb_hazard_masked", 64'(bus_b.hazard1), 64'd0);
    chk("r3_wb_nobypass_hazard", 64'(bus_n.hazard1), 64'd1);
    chk("r3_wb_bypass_data", 64'(bus_b.rd_data1), 64'hAAAA5555);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    chk("r3_cleared_cnt", 64'(bus_b.pend_cnt), 64'd0);
    chk("r3_cleared_hazard", 64'(bus_n.hazard1), 64'd0);
    chk("r3_data", 64'(bus_n.rd_data1), 64'hAAAA5555);

    // r9 pending, then issue+writeback r9 together: set wins.
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd4, 5'd9);
    step();
    drive(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd4, 5'd9);
    chk("r9_pend_cnt", 64'(bus_b.pend_cnt), 64'd1);
    chk("r9_same_cycle_masked", 64'(bus_b.hazard2), 64'd0);
    chk("r9_same_cycle_data", 64'(bus_b.rd_data2), 64'h99);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    chk("r9_still_pending", 64'(bus_b.hazard2), 64'd1);
    chk("r9_cnt_unchanged", 64'(bus_b.pend_cnt), 64'd1);
    chk("r9_data_updated", 64'(bus_n.rd_data2), 64'h99);
    // Issue r4 while retiring r9.
    drive(1'b1, 5'd9, 32'h00000999, 1'b1, 5'd4, 5'd4, 5'd9);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    chk("r4r9_cnt", 64'(bus_b.pend_cnt), 64'd1);
    chk("r4_pending", 64'(bus_b.hazard1), 64'd1);
    chk("r9_clear", 64'(bus_b.hazard2), 64'd0);
    drive(1'b1, 5'd4, 32'h00000444, 1'b0, 5'd0, 5'd4, 5'd9);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
    chk("r4_clear_cnt", 64'(bus_b.pend_cnt), 64'd0);

    // Saturation: issue every non-zero register, then retire them all.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'd0, 5'd0);
      if (i % 8 == 0) chk($sformatf("sat_cnt_%0d", i), 64'(bus_b.pend_cnt), 64'(i - 1));
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd0);
    chk("sat_full_cnt", 64'(bus_b.pend_cnt), 64'd31);
    chk("sat_hazard31", 64'(bus_b.hazard1), 64'd1);
    chk("sat_hazard_r0", 64'(bus_b.hazard2), 64'd0);
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h10000000 + 32'(i), 1'b0, 5'd0, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("sat_empty_cnt", 64'(bus_b.pend_cnt), 64'd0);
    chk("sat_empty_cnt_n", 64'(bus_n.pend_cnt), 64'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
      chk($sformatf("sweep_hazard1_r%0d", i), 64'(bus_b.hazard1), 64'd0);
      chk($sformatf("sweep_data1_r%0d", i), 64'(bus_n.rd_data1),
          (i == 0) ? 64'd0 : 64'(32'h10000000 + 32'(i)));
      chk($sformatf("sweep_data2_r%0d", 31 - i), 64'(bus_b.rd_data2),
          (i == 31) ? 64'd0 : 64'(32'h10000000 + 32'(31 - i)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
